prbs5_checker: RTL and testbench

PRBS5_CHECKER -- requirements
Module: prbs5_checker

---
 rtl/prbs5_checker_pkg.sv | 15 +
 rtl/sat_counter.sv | 19 +
 rtl/prbs5_checker.sv | 117 +++++++++++
 tb/tb_prbs5_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/prbs5_checker_pkg.sv
// Shared types and constants for the PRBS5 (x^5+x^3+1) checker.
package prbs_pkg;

    typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;

    localparam int TAP_A        = 4;
    localparam int TAP_B        = 2;
    localparam int PRBS5_LEN    = 5;
    localparam int PRBS5_PERIOD = 31;

    function automatic logic prbs5_next(input logic [PRBS5_LEN-1:0] s);
        return s[TAP_A] ^ s[TAP_B];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr beats inc on the same cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= '0;
        else if (inc && count != {W{1'b1}})
            count <= count + W'(1);
    end

endmodule

// File: rtl/prbs5_checker.sv
// PRBS5 receive checker: FILL -> SEARCH -> LOCKED with error counting.
// Define PRBS5_CHECKER_BITCNT_EN to add the bit_count output.
module prbs5_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
`ifdef PRBS5_CHECKER_BITCNT_EN
    ,
    output logic [ERR_W-1:0] bit_count
`endif
);

    state_t                 state;
    logic [PRBS5_LEN-1:0]   sr;
    logic [2:0]             fill;
    logic [4:0]             match_run;
    logic [3:0]             miss_run;
    logic                   expected;
    logic                   match;
    logic                   err_inc;

    assign expected = prbs5_next(sr);
    assign match    = (in_bit == expected);
    assign err_inc  = in_valid && (state == LOCKED) && !match;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            sr        <= '0;
            fill      <= '0;
            match_run <= '0;
            miss_run  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (state)
                    FILL: begin
                        sr <= {sr[3:0], in_bit};
                        if (fill == 3'(PRBS5_LEN - 1)) begin
                            state     <= SEARCH;
                            fill      <= '0;
                            match_run <= '0;
                        end else begin
                            fill <= fill + 3'd1;
                        end
                    end
                    SEARCH: begin
                        sr <= {sr[3:0], in_bit};
                        // all-zero window is the lock-up state, never a valid match
                        if (match && sr != '0) begin
                            if (match_run + 5'd1 == 5'(LOCK_CNT)) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_run <= '0;
                                miss_run  <= '0;
                            end else begin
                                match_run <= match_run + 5'd1;
                            end
                        end else begin
                            match_run <= '0;
                        end
                    end
                    LOCKED: begin
                        // self-run on the prediction so one channel error costs one mismatch
                        sr <= {sr[3:0], expected};
                        if (!match) begin
                            err_pulse <= 1'b1;
                            if (miss_run + 4'd1 == 4'(LOSS_CNT)) begin
                                state     <= SEARCH;
                                locked    <= 1'b0;
                                match_run <= '0;
                                miss_run  <= '0;
                            end else begin
                                miss_run <= miss_run + 4'd1;
                            end
                        end else begin
                            miss_run <= '0;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (clr_cnt),
        .count (err_count)
    );

`ifdef PRBS5_CHECKER_BITCNT_EN
    sat_counter #(.W(ERR_W)) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (in_valid && state == LOCKED),
        .clr   (clr_cnt),
        .count (bit_count)
    );
`endif

endmodule

// File: tb/tb_prbs5_checker.sv
// Scoreboard bench for prbs5_checker: default instance plus an ERR_W=4 instance on shared stimulus.
module tb_prbs5_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_bit;
    logic        clr_cnt;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked4, err_pulse4;
    logic [3:0]  err_count4;
`ifdef PRBS5_CHECKER_BITCNT_EN
    logic [15:0] bit_count;
    logic [3:0]  bit_count4;
`endif

    always #5 clk = ~clk;

    prbs5_checker dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
`ifdef PRBS5_CHECKER_BITCNT_EN
        ,
        .bit_count (bit_count)
`endif
    );

    prbs5_checker #(.ERR_W(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr_cnt   (clr_cnt),
        .locked    (locked4),
        .err_pulse (err_pulse4),
        .err_count (err_count4)
`ifdef PRBS5_CHECKER_BITCNT_EN
        ,
        .bit_count (bit_count4)
`endif
    );

    typedef struct {
        logic lk;
        logic pl;
        int   cnt;
        int   cnt4;
        bit   chk_lk;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [4:0]  g;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic gen_bit();
        logic fb;
        fb = g[2] ^ g[4];
        g  = {g[3:0], fb};
        return fb;
    endfunction

    // drive one cycle, push its expectation, then pop and compare after the edge
    task automatic step(input logic v, input logic b, input logic c,
                        input logic el, input logic ep, input int ec, input int ec4,
                        input bit cl);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        clr_cnt  = c;
        sbq.push_back('{el, ep, ec, ec4, cl});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        if (e.chk_lk) begin
            chk("locked", int'(locked), int'(e.lk));
            chk("locked4", int'(locked4), int'(e.lk));
        end
        chk("err_pulse", int'(err_pulse), int'(e.pl));
        chk("err_count", int'(err_count), e.cnt);
        chk("err_count4", int'(err_count4), e.cnt4);
    endtask

    // reset held with valid and clr active to show it overrides both
    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        clr_cnt  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_pulse", int'(err_pulse), 0);
        chk("rst_count", int'(err_count), 0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        g        = 5'b00001;
    endtask

    initial begin
        logic b;
        int   n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clr_cnt  = 1'b0;
        g        = 5'b00001;

        // clean stream: lock after the 13th bit, no errors over 200 bits
        do_reset();
        for (int i = 1; i <= 200; i++) begin
            b = gen_bit();
            step(1'b1, b, 1'b0, (i >= 13), 1'b0, 0, 0, 1'b1);
        end

        // single flipped bit while locked
        for (int i = 0; i < 5; i++) step(1'b1, gen_bit(), 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
        step(1'b1, ~gen_bit(), 1'b0, 1'b1, 1'b1, 1, 1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, gen_bit(), 1'b0, 1'b1, 1'b0, 1, 1, 1'b1);

        // clear, then a burst of 4 errors drops lock on the 4th
        step(1'b1, gen_bit(), 1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        for (int i = 1; i <= 4; i++)
            step(1'b1, ~gen_bit(), 1'b0, (i < 4), 1'b1, i, i, 1'b1);
        n = 0;
        do begin
            n++;
            step(1'b1, gen_bit(), 1'b0, 1'b0, 1'b0, 4, 4, 1'b0);
        end while (!locked && n < 40);
        chk("relock_bits", n, 8);

        // reset mid-stream drops lock
        do_reset();

        // all-zero input never locks
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

        // gapped stream: lock counts only valid bits, idle cycles never pulse
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, gen_bit(), 1'b0, (i >= 13), 1'b0, 0, 0, 1'b1);
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, (i >= 13), 1'b0, 0, 0, 1'b1);
        end

        // saturation on the 4-bit instance, then clear beats a coincident error
        do_reset();
        for (int i = 1; i <= 13; i++) step(1'b1, gen_bit(), 1'b0, (i >= 13), 1'b0, 0, 0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, ~gen_bit(), 1'b0, 1'b1, 1'b1, k, (k > 15) ? 15 : k, 1'b1);
            step(1'b1, gen_bit(), 1'b0, 1'b1, 1'b0, k, (k > 15) ? 15 : k, 1'b1);
            step(1'b1, gen_bit(), 1'b0, 1'b1, 1'b0, k, (k > 15) ? 15 : k, 1'b1);
        end
        step(1'b1, ~gen_bit(), 1'b1, 1'b1, 1'b1, 0, 0, 1'b1);
        step(1'b1, gen_bit(), 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
